// File: rtl/jtkunio_rom_arb_if.sv
// Bus bundle for jtkunio_rom_arb: two client channels (char = c0,
// scroll = c1) plus the shared graphics ROM channel.
// slave  : the arbiter's view (serves clients, drives the ROM request).
// master : the surrounding system's view (tile layers + ROM controller).
interface jtkunio_rom_arb_if #(
    parameter int AW = 17,
    parameter int DW = 32
);
    logic          c0_cs;
    logic [AW-1:0] c0_addr;
    logic [DW-1:0] c0_data;
    logic          c0_ok;

    logic          c1_cs;
    logic [AW-1:0] c1_addr;
    logic [DW-1:0] c1_data;
    logic          c1_ok;

    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          rom_ok;

    modport slave (
        input  c0_cs, c0_addr, c1_cs, c1_addr, rom_data, rom_ok,
        output c0_data, c0_ok, c1_data, c1_ok, rom_cs, rom_addr
    );

    modport master (
        output c0_cs, c0_addr, c1_cs, c1_addr, rom_data, rom_ok,
        input  c0_data, c0_ok, c1_data, c1_ok, rom_cs, rom_addr
    );
endinterface

// File: rtl/jtkunio_rom_arb.sv
// jtkunio_rom_arb: shares one graphics ROM port between the char (c0) and
// scroll (c1) layers. Each client is backed by a one-entry cache; the ROM
// port carries at most one outstanding fetch.
// Build option: define JTKUNIO_ARB_RR_EN for round-robin tie-breaking;
// otherwise client 0 always wins a simultaneous miss.
module jtkunio_rom_arb #(
    parameter int         AW  = 17,
    parameter int         DW  = 32,
    parameter logic [7:0] TMO = 8'd200
) (
    input  logic             clk,
    input  logic             rst_n,
    jtkunio_rom_arb_if.slave bus
);
    localparam int NUM_CL = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // client-side views gathered into packed arrays, index = client number
    logic [NUM_CL-1:0]         cs;
    logic [NUM_CL-1:0][AW-1:0] addr;
    logic [NUM_CL-1:0]         hit;
    logic [NUM_CL-1:0]         miss;
    logic [NUM_CL-1:0]         val;
    logic [NUM_CL-1:0][AW-1:0] tag;
    logic [NUM_CL-1:0][DW-1:0] dat;

    logic          own;       // client that owns the fetch in flight
    logic          win;       // arbitration result in IDLE
    logic          grant;     // IDLE -> ISSUE this cycle
    logic          fill;      // accept rom_data into the owner's cache
    logic          tmo_hit;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [7:0]    cnt;

    assign cs   = {bus.c1_cs,   bus.c0_cs};
    assign addr = {bus.c1_addr, bus.c0_addr};

    // per-client cache lookup; ok is purely combinational on the tag compare
    // so it falls in the very cycle the client moves to a new address
    for (genvar g = 0; g < NUM_CL; g++) begin : g_cl
        assign hit[g]  = val[g] && (tag[g] == addr[g]);
        assign miss[g] = cs[g] && !hit[g];

        // cache entry: only written by a completed fetch owned by this client
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                val[g] <= 1'b0;
                tag[g] <= '0;
                dat[g] <= '0;
            end else if (fill && (own == 1'(g))) begin
                val[g] <= 1'b1;
                tag[g] <= rom_addr;
                dat[g] <= bus.rom_data;
            end
        end
    end

    assign bus.c0_ok   = cs[0] & hit[0];
    assign bus.c1_ok   = cs[1] & hit[1];
    assign bus.c0_data = dat[0];
    assign bus.c1_data = dat[1];

`ifdef JTKUNIO_ARB_RR_EN
    logic last;   // client granted most recently

    // round-robin: on a tie the client not granted last goes first
    always_comb begin
        win = 1'b0;
        if (miss == 2'b11)
            win = ~last;
        else
            win = ~miss[0];
    end

    // last-grant register, refreshed on every new fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (grant)
            last <= win;
    end
`else
    // fixed priority: char layer wins whenever it misses
    always_comb begin
        win = ~miss[0];
    end
`endif

    // timeout fires on the TMO-th WAIT cycle without an answer
    assign tmo_hit = ({1'b0, cnt} + 9'd1) >= {1'b0, TMO};

    // next-state and ROM request; the ISSUE cycle never samples rom_ok so a
    // lingering ok from the previous access cannot satisfy the new one
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        fill      = 1'b0;
        rom_cs    = 1'b0;
        case (state)
            S_IDLE: begin
                if (|miss) begin
                    grant     = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rom_cs    = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                rom_cs = 1'b1;
                if (bus.rom_ok) begin
                    fill      = 1'b1;
                    state_nxt = S_IDLE;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.rom_cs   = rom_cs;
    assign bus.rom_addr = rom_addr;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // fetch context: address and owner are frozen for the whole fetch, so
    // client address changes mid-fetch do not disturb it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            own      <= 1'b0;
        end else if (grant) begin
            rom_addr <= addr[win];
            own      <= win;
        end
    end

    // saturating timeout counter, restarted for every new fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (grant)
            cnt <= '0;
        else if (state == S_WAIT && cnt != 8'hFF)
            cnt <= cnt + 8'd1;
    end
endmodule

// File: tb/tb_jtkunio_rom_arb.sv
// Directed bench for jtkunio_rom_arb. Expected ROM fetches (address + the
// data the bench will return) are queued when a client request is driven
// and popped when the arbiter issues on the ROM port.
module tb_jtkunio_rom_arb;
    localparam int         AW  = 17;
    localparam int         DW  = 32;
    localparam logic [7:0] TMO = 8'd12;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } fetch_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    int     n_vec = 0;
    int     n_err = 0;
    fetch_t exp_q[$];
    logic   last_g = 1'b1;   // bench model of the last-grant register

    jtkunio_rom_arb_if #(.AW(AW), .DW(DW)) bus ();

    jtkunio_rom_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return 32'h5A000000 ^ {15'd0, a} ^ ({15'd0, a} << 12);
    endfunction

    function automatic fetch_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
        fetch_t f;
        f.addr = a;
        f.data = d;
        return f;
    endfunction

    // drive point: just after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // wait for the next ISSUE, check its address, answer after lat extra
    // WAIT cycles; returns at the sample point of the cycle after rom_ok
    task automatic serve(input int lat, output int gap);
        fetch_t f;
        int n;
        n = 0;
        cyc();
        @(negedge clk);
        while (bus.rom_cs !== 1'b1 && n < 50) begin
            cyc();
            @(negedge clk);
            n++;
        end
        gap = n;
        chk("issue_seen", 64'(n < 50), 64'(1));
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() == 0) return;
        f = exp_q.pop_front();
        chk("rom_addr", 64'(bus.rom_addr), 64'(f.addr));
        for (int i = 0; i < lat; i++) begin
            cyc();
            @(negedge clk);
            chk("rom_cs_wait", 64'(bus.rom_cs), 64'(1));
        end
        cyc();
        bus.rom_ok   = 1'b1;
        bus.rom_data = f.data;
        @(negedge clk);
        chk("rom_cs_at_ok", 64'(bus.rom_cs), 64'(1));
        cyc();
        bus.rom_ok   = 1'b0;
        bus.rom_data = '0;
        @(negedge clk);
        chk("rom_cs_after_ok", 64'(bus.rom_cs), 64'(0));
    endtask

    initial begin
        int gap;
        int n;
        logic w;
        logic [AW-1:0] a0, a1;

        bus.c0_cs = 1'b1;  bus.c0_addr = '0;
        bus.c1_cs = 1'b0;  bus.c1_addr = '0;
        bus.rom_ok = 1'b0; bus.rom_data = '0;

        // ---- reset state (c0 requests tag-matching address 0: val must block ok)
        repeat (2) @(negedge clk);
        chk("rst_rom_cs",   64'(bus.rom_cs),   64'(0));
        chk("rst_rom_addr", 64'(bus.rom_addr), 64'(0));
        chk("rst_c0_ok",    64'(bus.c0_ok),    64'(0));
        chk("rst_c1_ok",    64'(bus.c1_ok),    64'(0));
        chk("rst_c0_data",  64'(bus.c0_data),  64'(0));
        chk("rst_c1_data",  64'(bus.c1_data),  64'(0));
        cyc();
        rst_n = 1'b1;
        bus.c0_cs = 1'b0;
        @(negedge clk);
        chk("post_rst_rom_cs", 64'(bus.rom_cs), 64'(0));

        // ---- single miss
        cyc();
        bus.c0_cs = 1'b1; bus.c0_addr = 17'h00123;
        exp_q.push_back(mk(17'h00123, 32'hDEADBEEF));
        @(negedge clk);
        chk("miss_c0_ok",   64'(bus.c0_ok),  64'(0));
        chk("miss_rom_cs0", 64'(bus.rom_cs), 64'(0));
        serve(0, gap);
        chk("miss_gap", 64'(gap), 64'(0));
        chk("miss_c0_ok_t3",   64'(bus.c0_ok),   64'(1));
        chk("miss_c0_data_t3", 64'(bus.c0_data), 64'(32'hDEADBEEF));
        last_g = 1'b0;

        // ---- hit: move away for one cycle and come back
        cyc();
        bus.c0_addr = 17'h00124;
        exp_q.push_back(mk(17'h00124, word(17'h00124)));
        @(negedge clk);
        chk("hit_away_ok", 64'(bus.c0_ok), 64'(0));
        cyc();
        bus.c0_addr = 17'h00123;
        @(negedge clk);
        chk("hit_back_ok",   64'(bus.c0_ok),    64'(1));
        chk("hit_back_data", 64'(bus.c0_data),  64'(32'hDEADBEEF));
        chk("hit_issue_old", 64'(bus.rom_addr), 64'(17'h00124));
        bus.c0_cs = 1'b0;
        serve(0, gap);
        last_g = 1'b0;
        cyc();
        bus.c0_cs = 1'b1; bus.c0_addr = 17'h00124;
        @(negedge clk);
        chk("hit2_ok",     64'(bus.c0_ok),   64'(1));
        chk("hit2_data",   64'(bus.c0_data), 64'(word(17'h00124)));
        chk("hit2_no_rom", 64'(bus.rom_cs),  64'(0));
        cyc();
        @(negedge clk);
        chk("hit2_no_rom_next", 64'(bus.rom_cs), 64'(0));

        // ---- collisions
        for (int i = 0; i < 2; i++) begin
            a0 = 17'h00010 + 17'(i);
            a1 = 17'h10020 + 17'(i);
`ifdef JTKUNIO_ARB_RR_EN
            w = ~last_g;
`else
            w = 1'b0;
`endif
            cyc();
            bus.c0_cs = 1'b1; bus.c0_addr = a0;
            bus.c1_cs = 1'b1; bus.c1_addr = a1;
            if (w == 1'b0) begin
                exp_q.push_back(mk(a0, word(a0)));
                exp_q.push_back(mk(a1, word(a1)));
            end else begin
                exp_q.push_back(mk(a1, word(a1)));
                exp_q.push_back(mk(a0, word(a0)));
            end
            last_g = ~w;
            @(negedge clk);
            chk("col_c0_ok0", 64'(bus.c0_ok), 64'(0));
            chk("col_c1_ok0", 64'(bus.c1_ok), 64'(0));
            serve(0, gap);
            chk("col_first_gap", 64'(gap), 64'(0));
            chk("col_win_ok",  64'(w ? bus.c1_ok : bus.c0_ok), 64'(1));
            chk("col_lose_ok", 64'(w ? bus.c0_ok : bus.c1_ok), 64'(0));
            serve(0, gap);
            chk("col_b2b_gap", 64'(gap), 64'(0));
            chk("col_c0_ok",   64'(bus.c0_ok),   64'(1));
            chk("col_c1_ok",   64'(bus.c1_ok),   64'(1));
            chk("col_c0_data", 64'(bus.c0_data), 64'(word(a0)));
            chk("col_c1_data", 64'(bus.c1_data), 64'(word(a1)));
        end
        cyc();
        bus.c0_cs = 1'b0; bus.c1_cs = 1'b0;

        // ---- stale ok: rom_ok high throughout, data changes only in WAIT
        cyc();
        bus.rom_ok = 1'b1; bus.rom_data = 32'hBADBAD00;
        bus.c1_cs = 1'b1;  bus.c1_addr = 17'h00300;
        exp_q.push_back(mk(17'h00300, 32'h600D600D));
        @(negedge clk);
        chk("stale_idle_cs", 64'(bus.rom_cs), 64'(0));
        cyc();
        @(negedge clk);
        chk("stale_issue_cs", 64'(bus.rom_cs), 64'(1));
        chk("stale_issue_ok", 64'(bus.c1_ok),  64'(0));
        chk("stale_sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0)
            chk("stale_rom_addr", 64'(bus.rom_addr), 64'(exp_q.pop_front().addr));
        cyc();
        bus.rom_data = 32'h600D600D;
        @(negedge clk);
        chk("stale_wait_cs", 64'(bus.rom_cs), 64'(1));
        chk("stale_wait_ok", 64'(bus.c1_ok),  64'(0));
        cyc();
        bus.rom_ok = 1'b0; bus.rom_data = '0;
        @(negedge clk);
        chk("stale_done_cs",   64'(bus.rom_cs),  64'(0));
        chk("stale_done_ok",   64'(bus.c1_ok),   64'(1));
        chk("stale_done_data", 64'(bus.c1_data), 64'(32'h600D600D));
        last_g = 1'b1;

        // ---- address change mid-fetch
        cyc();
        bus.c1_addr = 17'h00400;
        exp_q.push_back(mk(17'h00400, word(17'h00400)));
        @(negedge clk);
        chk("chg_ok0", 64'(bus.c1_ok), 64'(0));
        cyc();
        @(negedge clk);
        chk("chg_issue_cs", 64'(bus.rom_cs), 64'(1));
        chk("chg_sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0)
            chk("chg_rom_addr", 64'(bus.rom_addr), 64'(exp_q.pop_front().addr));
        cyc();
        bus.c1_addr = 17'h00401;
        exp_q.push_back(mk(17'h00401, word(17'h00401)));
        @(negedge clk);
        chk("chg_wait_addr", 64'(bus.rom_addr), 64'(17'h00400));
        cyc();
        bus.rom_ok = 1'b1; bus.rom_data = word(17'h00400);
        @(negedge clk);
        cyc();
        bus.rom_ok = 1'b0; bus.rom_data = '0;
        @(negedge clk);
        chk("chg_done_cs",   64'(bus.rom_cs),  64'(0));
        chk("chg_done_ok",   64'(bus.c1_ok),   64'(0));
        chk("chg_done_data", 64'(bus.c1_data), 64'(word(17'h00400)));
        serve(0, gap);
        chk("chg_refetch_gap", 64'(gap), 64'(0));
        chk("chg_new_ok",   64'(bus.c1_ok),   64'(1));
        chk("chg_new_data", 64'(bus.c1_data), 64'(word(17'h00401)));

        // ---- timeout and re-issue (c1 keeps hitting on 0x401)
        cyc();
        bus.c0_cs = 1'b1; bus.c0_addr = 17'h00500;
        exp_q.push_back(mk(17'h00500, word(17'h00500)));
        exp_q.push_back(mk(17'h00500, word(17'h00500)));
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("tmo_sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0)
            chk("tmo_rom_addr", 64'(bus.rom_addr), 64'(exp_q.pop_front().addr));
        n = 0;
        while (bus.rom_cs === 1'b1 && n < 300) begin
            n++;
            cyc();
            @(negedge clk);
        end
        chk("tmo_cs_len", 64'(n), 64'(int'(TMO) + 1));
        chk("tmo_c0_ok",  64'(bus.c0_ok), 64'(0));
        cyc();
        @(negedge clk);
        chk("tmo_reissue_cs", 64'(bus.rom_cs), 64'(1));
        chk("tmo_sb_nonempty2", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0)
            chk("tmo_reissue_addr", 64'(bus.rom_addr), 64'(exp_q.pop_front().addr));
        cyc();
        @(negedge clk);
        chk("tmo_wait_cs", 64'(bus.rom_cs), 64'(1));
        chk("tmo_c1_hit",  64'(bus.c1_ok),  64'(1));

        // ---- asynchronous reset in the middle of WAIT
        rst_n = 1'b0;
        #1;
        chk("arst_rom_cs",   64'(bus.rom_cs),   64'(0));
        chk("arst_c0_ok",    64'(bus.c0_ok),    64'(0));
        chk("arst_c1_ok",    64'(bus.c1_ok),    64'(0));
        chk("arst_c1_data",  64'(bus.c1_data),  64'(0));
        chk("arst_rom_addr", 64'(bus.rom_addr), 64'(0));
        bus.c0_cs = 1'b0; bus.c1_cs = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_cs", 64'(bus.rom_cs), 64'(0));
        cyc();
        @(negedge clk);
        chk("arst_idle_cs", 64'(bus.rom_cs), 64'(0));
        chk("sb_drained",   64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/jtkunio_rom_arb.md
# jtkunio_rom_arb

Two-client arbiter that shares one graphics ROM port between the character layer and the scroll layer of the Kunio video subsystem. Each client sees a private address/data/ok interface backed by a one-entry cache. The shared port sees at most one outstanding fetch at a time. The block sits between the tile layers and the SDRAM/ROM controller channel.

## Interface
Parameters:
- AW, 17, ROM word address width; narrower client addresses are zero-extended by the instantiating level.
- DW, 32, ROM data width.
- TMO, 8'd200, timeout in clk cycles before an unanswered fetch is re-issued.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: one clock, asynchronous and active-low
- c0_cs  in  1  char client request
- c0_addr  in  AW  char client address
- c0_data  out  DW  char client data, from cache
- c0_ok  out  1  char client data valid for current c0_addr
- c1_cs  in  1  scroll client request
- c1_addr  in  AW  scroll client address
- c1_data  out  DW  scroll client data, from cache
- c1_ok  out  1  scroll client data valid for current c1_addr
- rom_cs  out  1  shared port request
- rom_addr  out  AW  shared port address, registered
- rom_data  in  DW  shared port data
- rom_ok  in  1  shared port data valid

## Operation
- Per client n: cache registers tag_n[AW], dat_n[DW], val_n.
- cn_ok = cn_cs & val_n & (tag_n == cn_addr). This is combinational on the address compare, so it drops in the same cycle the address changes.
- cn_data = dat_n at all times.
- miss_n = cn_cs & ~(val_n & tag_n == cn_addr).
- FSM states:
  - IDLE:
    - If any miss_n, select a winner, latch rom_addr = cn_addr of the winner, latch own = winner, go to ISSUE.
    - With both missing, the winner follows the Configuration section.
  - ISSUE:
    - rom_cs = 1. Hold rom_addr. Ignore rom_ok for this cycle (dead cycle, so stale ok from a previous access is rejected). Go to WAIT.
  - WAIT:
    - rom_cs = 1. On rom_ok: tag_own = rom_addr, dat_own = rom_data, val_own = 1, rom_cs = 0, go to IDLE.
    - If the timeout counter reaches TMO first, drop rom_cs for one cycle and go to IDLE (re-arbitrated; no cache update).
- Timeout counter: 8 bits, cleared on ISSUE entry, increments in WAIT, saturates.
- A client's address change or cs drop during a fetch does not abort the fetch. The fetch completes and fills the cache with the old address. The client then re-misses and is re-arbitrated.
- The cache is never invalidated except by reset.

## Timing
- Reset values: rom_cs = 0, rom_addr = 0, c0_ok = c1_ok = 0, c0_data = c1_data = 0, all val_n = 0, FSM = IDLE, last-grant = client 1 (so client 0 wins the first tie).
- Miss detected in cycle t (IDLE):
  - rom_cs rises at t+1 (ISSUE).
  - rom_ok is accepted from t+2.
- rom_ok at cycle k: cache written at k, cn_ok high at k+1 if the address is unchanged, rom_cs low at k+1.
- Minimum miss-to-ok latency is 3 cycles (ok at t+2, client ok at t+3). Back-to-back fetches are 3 cycles apart minimum.
- rom_ok in IDLE or ISSUE is ignored.
- Hit: cn_ok in the same cycle as the address presentation, no ROM traffic.

## Configuration
- JTKUNIO_ARB_RR_EN defined: round-robin. On a simultaneous miss, the client not granted last wins. The last-grant register updates on every IDLE->ISSUE transition.
- Not defined: fixed priority. Client 0 (char) always wins a simultaneous miss; the last-grant register is absent.

## Test plan
- Single miss: c0_cs = 1, c0_addr = 0x00123; ROM answers rom_ok one cycle after ISSUE with 0xDEADBEEF -> rom_cs high for 2 cycles, rom_addr = 0x00123, c0_ok = 1 and c0_data = 0xDEADBEEF three cycles after the request.
- Hit: after the above, toggle c0_addr 0x00124 -> 0x00123 -> c0_ok back high the same cycle 0x00123 returns, with no rom_cs activity for the return.
- Collision: c0 and c1 miss in the same cycle (0x00010, 0x10020):
  - With the macro: grants alternate c0, c1 over repeated collisions.
  - Without: c0 is always first, c1 is served next.
- Stale ok: rom_ok held high continuously -> a new fetch still holds rom_cs ≥2 cycles, and the captured data comes from a WAIT-cycle rom_ok.
- Address change mid-fetch: c1_addr changes during WAIT -> the fetch completes with the old tag, c1_ok stays 0, a second fetch with the new address follows.
- Timeout and reset: rom_ok never asserted -> rom_cs drops after TMO WAIT cycles and the request is re-issued. Asserting rst_n = 0 mid-WAIT -> rom_cs = 0 and both ok outputs = 0 immediately.
